seg7_display_ctrl: RTL and testbench

Parametrised multi-digit 7-segment display controller. It holds one 4-bit value per digit in internal registers loaded through a simple write port, and decodes full hex or decimal-only. Adds per-digit blanking, per-digit blink driven by an internal divider, and optional leading-zero suppression. It drives all HEXn displays of the board from one registered, flattened segment bus.

---
 rtl/seg7_display_ctrl.sv | 136 +++++++++++++
 tb/tb_seg7_display_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/seg7_display_ctrl.sv
// Multi-digit 7-segment controller: per-digit value/valid/blink storage, hex or decimal decode,
// blink divider, leading-zero suppression, and one registered flattened segment bus.
module seg7_lane #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] i_val,
  input  logic       i_valid,
  input  logic       i_blink,
  input  logic       i_phase,
  input  logic       i_hex_mode,
  input  logic       i_suppress,
  output logic [6:0] o_seg
);
  logic [6:0] w_pat;
  logic       w_blank;

  // Patterns are active-low, bit order g..a
  always_comb begin
    w_pat = 7'b1111111;
    case (i_val)
      4'h0: w_pat = 7'b1000000;
      4'h1: w_pat = 7'b1111001;
      4'h2: w_pat = 7'b0100100;
      4'h3: w_pat = 7'b0110000;
      4'h4: w_pat = 7'b0011001;
      4'h5: w_pat = 7'b0010010;
      4'h6: w_pat = 7'b0000010;
      4'h7: w_pat = 7'b1111000;
      4'h8: w_pat = 7'b0000000;
      4'h9: w_pat = 7'b0010000;
      4'hA: w_pat = 7'b0001000;
      4'hB: w_pat = 7'b0000011;
      4'hC: w_pat = 7'b1000110;
      4'hD: w_pat = 7'b0100001;
      4'hE: w_pat = 7'b0000110;
      4'hF: w_pat = 7'b0001110;
      default: w_pat = 7'b1111111;
    endcase
  end

  assign w_blank = !i_valid || (!i_hex_mode && (i_val > 4'd9)) || (i_blink && i_phase) || i_suppress;

  always_comb begin
    o_seg = w_blank ? 7'b1111111 : w_pat;
    if (!ACTIVE_LOW) o_seg = ~o_seg;
  end
endmodule

module seg7_display_ctrl #(
  parameter  int NUM_DIGITS = 8,
  parameter  int BLINK_DIV  = 25000000,
  parameter  bit ACTIVE_LOW = 1'b1,
  localparam int AW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CW = (BLINK_DIV  > 1) ? $clog2(BLINK_DIV)  : 1
) (
  input  logic                    CLOCK_50,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [3:0]              wr_data,
  input  logic                    wr_blink,
  input  logic                    clr,
  input  logic                    hex_mode,
  input  logic                    lz_suppress,
  output logic [NUM_DIGITS*7-1:0] seg_out
);
  logic [NUM_DIGITS-1:0][3:0] r_val;
  logic [NUM_DIGITS-1:0]      r_valid, r_blink;
  logic [CW-1:0]              r_cnt;
  logic                       r_phase;
  logic [NUM_DIGITS*7-1:0]    r_seg;
  logic [NUM_DIGITS-1:0][6:0] w_seg;
  logic [NUM_DIGITS-1:0]      w_sig, w_sup;
  logic                       w_wr_ok;

  assign w_wr_ok = wr_en && (32'(wr_addr) < NUM_DIGITS);

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      r_val   <= '0;
      r_valid <= '0;
      r_blink <= '0;
    end else if (clr) begin
      r_valid <= '0;
      r_blink <= '0;
    end else if (w_wr_ok) begin
      r_val[wr_addr]   <= wr_data;
      r_valid[wr_addr] <= 1'b1;
      r_blink[wr_addr] <= wr_blink;
    end
  end

  // Divider runs independently of writes and clr
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == CW'(BLINK_DIV - 1)) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  // A digit is significant when it holds a nonzero value, even if decimal- or blink-blanked
  always_comb begin
    logic w_acc;
    w_acc = 1'b0;
    w_sup = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_sup[i] = lz_suppress && (i != 0) && !w_acc && !w_sig[i];
      w_acc    = w_acc | w_sig[i];
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
    assign w_sig[g] = r_valid[g] && (r_val[g] != 4'd0);
    seg7_lane #(.ACTIVE_LOW(ACTIVE_LOW)) u_lane (
      .i_val      (r_val[g]),
      .i_valid    (r_valid[g]),
      .i_blink    (r_blink[g]),
      .i_phase    (r_phase),
      .i_hex_mode (hex_mode),
      .i_suppress (w_sup[g]),
      .o_seg      (w_seg[g])
    );
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) r_seg <= {(NUM_DIGITS*7){ACTIVE_LOW}};
    else        r_seg <= w_seg;
  end

  assign seg_out = r_seg;
endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed bench for seg7_display_ctrl: three instances (active-low 8 digits, active-high 8 digits,
// active-low 6 digits) share one stimulus stream; expected patterns are hand-written constants.
module tb_seg7_display_ctrl;
  logic        CLOCK_50 = 1'b0;
  logic        rst_n = 1'b0, wr_en = 1'b0, wr_blink = 1'b0, clr = 1'b0, hex_mode = 1'b0, lz_suppress = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [3:0]  wr_data = '0;
  logic [55:0] seg_a, seg_b;
  logic [41:0] seg_c;
  int          n_run = 0, n_fail = 0;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S3 = 7'b0110000, S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000, S8 = 7'b0000000, SA = 7'b0001000, SC = 7'b1000110;
  localparam logic [6:0] OFF = 7'b1111111;

  always #5 CLOCK_50 = ~CLOCK_50;

  seg7_display_ctrl #(.NUM_DIGITS(8), .BLINK_DIV(4), .ACTIVE_LOW(1'b1)) dut_a (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_blink(wr_blink), .clr(clr), .hex_mode(hex_mode), .lz_suppress(lz_suppress), .seg_out(seg_a));
  seg7_display_ctrl #(.NUM_DIGITS(8), .BLINK_DIV(4), .ACTIVE_LOW(1'b0)) dut_b (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_blink(wr_blink), .clr(clr), .hex_mode(hex_mode), .lz_suppress(lz_suppress), .seg_out(seg_b));
  seg7_display_ctrl #(.NUM_DIGITS(6), .BLINK_DIV(4), .ACTIVE_LOW(1'b1)) dut_c (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_blink(wr_blink), .clr(clr), .hex_mode(hex_mode), .lz_suppress(lz_suppress), .seg_out(seg_c));

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [55:0] obs, input logic [55:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] d, input logic b);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_blink = b;
    tick();
    wr_en = 1'b0; wr_blink = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state, held even with a write pulsed
    tick();
    tick();
    chk("rst_a", seg_a, {56{1'b1}});
    chk("rst_b", seg_b, 56'h0);
    chk("rst_c", {14'h0, seg_c}, {14'h0, {42{1'b1}}});
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'h8;
    tick();
    tick();
    wr_en = 1'b0;
    chk("rst_wr_held", seg_a, {56{1'b1}});
    rst_n = 1'b1;

    // Blink with BLINK_DIV=4; the reset edge above left the divider at 0
    hex_mode = 1'b1;
    wr(3'd0, 4'h7, 1'b1);                               // E1
    wr(3'd1, 4'h1, 1'b0);                               // E2
    tick(); chk("blink_e3_on",  seg_a, {{42{1'b1}}, S1, S7});
    tick(); chk("blink_e4_on",  seg_a, {{42{1'b1}}, S1, S7});
    tick(); chk("blink_e5_off", seg_a, {{42{1'b1}}, S1, OFF});
    tick(); tick();
    tick(); chk("blink_e8_off", seg_a, {{42{1'b1}}, S1, OFF});
    tick(); chk("blink_e9_on",  seg_a, {{42{1'b1}}, S1, S7});
    tick(); tick(); tick();
    tick(); chk("blink_e13_off", seg_a, {{42{1'b1}}, S1, OFF});
    rst_n = 1'b0;
    tick(); chk("blink_midrst", seg_a, {56{1'b1}});
    tick();
    rst_n = 1'b1;
    wr(3'd0, 4'h7, 1'b1);
    wr(3'd1, 4'h1, 1'b0);
    tick(); chk("blink_restart_on",  seg_a, {{42{1'b1}}, S1, S7});
    tick(); tick(); chk("blink_restart_off", seg_a, {{42{1'b1}}, S1, OFF});

    // Hex decode and hex_mode switching
    do_reset();
    hex_mode = 1'b1;
    wr(3'd0, 4'hA, 1'b0);
    wr(3'd1, 4'h3, 1'b0);
    tick(); chk("hex_A3", seg_a, {{42{1'b1}}, S3, SA});
    hex_mode = 1'b0;
    wr(3'd0, 4'hC, 1'b0);
    tick(); chk("dec_C_blank", seg_a, {{42{1'b1}}, S3, OFF});
    hex_mode = 1'b1;
    tick(); chk("hex_C_show", seg_a, {{42{1'b1}}, S3, SC});

    // Polarity: digit0=8
    wr(3'd0, 4'h8, 1'b0);
    tick();
    chk("al1_8", seg_a, {{42{1'b1}}, S3, S8});
    chk("al0_8", seg_b, {42'h0, ~S3, ~S8});
    chk("n6_8",  {14'h0, seg_c}, {14'h0, {28{1'b1}}, S3, S8});

    // clr beats a same-cycle write
    clr = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'h9;
    tick();
    clr = 1'b0; wr_en = 1'b0;
    tick(); chk("clr_wins", seg_a, {56{1'b1}});

    // Out-of-range address on the 6-digit instance
    wr(3'd7, 4'h8, 1'b0);
    tick();
    chk("addr7_n8", seg_a, {S8, {49{1'b1}}});
    chk("addr7_n6_ignored", {14'h0, seg_c}, {14'h0, {42{1'b1}}});

    // Leading-zero suppression
    do_reset();
    hex_mode = 1'b1; lz_suppress = 1'b1;
    wr(3'd3, 4'h0, 1'b0);
    wr(3'd2, 4'h0, 1'b0);
    wr(3'd1, 4'h5, 1'b0);
    wr(3'd0, 4'h0, 1'b0);
    tick(); chk("lz_0050", seg_a, {{28{1'b1}}, OFF, OFF, S5, S0});
    wr(3'd1, 4'h0, 1'b0);
    tick(); chk("lz_all0", seg_a, {{49{1'b1}}, S0});
    lz_suppress = 1'b0;
    tick(); chk("lz_off", seg_a, {{28{1'b1}}, S0, S0, S0, S0});
    lz_suppress = 1'b1; hex_mode = 1'b0;
    wr(3'd2, 4'hC, 1'b0);
    tick(); chk("lz_dec_sig", seg_a, {{28{1'b1}}, OFF, OFF, S0, S0});

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
